// File: rtl/coh_pkg.sv
// Shared MSI directory-protocol definitions: opcodes, line states, source ID width,
// and the cache-side agent state encoding.
package coh_pkg;

    localparam int unsigned SRC_W = 2;

    typedef enum logic [2:0] {
        OP_NOOP  = 3'd0,
        OP_REPLY = 3'd2,
        OP_RD    = 3'd3,
        OP_WR    = 3'd4,
        OP_INV   = 3'd5,
        OP_UPD   = 3'd6,
        OP_RWITM = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        LS_I = 2'd0,
        LS_S = 2'd1,
        LS_M = 2'd2
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RPY,
        ST_SNP_LOOK,
        ST_SNP_WB,
        ST_DONE
    } agent_state_e;

    // Line state granted by the directory once the request it answers completes.
    function automatic logic [1:0] fill_state(op_e op);
        logic [1:0] st;
        unique case (op)
            OP_RD:             st = LS_S;
            OP_RWITM, OP_UPD:  st = LS_M;
            default:           st = LS_I;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cache_dir_agent_if.sv
// Directory-side request and message channels of the cache coherence agent.
interface cache_dir_agent_if
    import coh_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128
);

    logic              dir_req_valid;
    logic              dir_req_ready;
    logic [2:0]        dir_req_op;
    logic [SRC_W-1:0]  dir_req_src;
    logic [ADDR_W-1:0] dir_req_addr;
    logic [LINE_W-1:0] dir_req_data;

    logic              dir_msg_valid;
    logic              dir_msg_ready;
    logic [2:0]        dir_msg_op;
    logic [SRC_W-1:0]  dir_msg_dest;
    logic [ADDR_W-1:0] dir_msg_addr;
    logic [LINE_W-1:0] dir_msg_data;

    modport master (
        output dir_req_valid, dir_req_op, dir_req_src, dir_req_addr, dir_req_data,
        input  dir_req_ready,
        input  dir_msg_valid, dir_msg_op, dir_msg_dest, dir_msg_addr, dir_msg_data,
        output dir_msg_ready
    );

    modport slave (
        input  dir_req_valid, dir_req_op, dir_req_src, dir_req_addr, dir_req_data,
        output dir_req_ready,
        output dir_msg_valid, dir_msg_op, dir_msg_dest, dir_msg_addr, dir_msg_data,
        input  dir_msg_ready
    );

endinterface

// File: rtl/cache_dir_req_map.sv
// Maps a cache request (store/evict/current state) to the directory opcode it needs,
// or to the line state reported immediately when no directory traffic is required.
module cache_dir_req_map
    import coh_pkg::*;
(
    input  logic       is_st,
    input  logic       evict,
    input  logic [1:0] line_state,
    output op_e        op,
    output logic       needs_dir,
    output logic [1:0] imm_state
);

    always_comb begin
        op        = OP_NOOP;
        needs_dir = 1'b0;
        imm_state = line_state;
        if (evict) begin
            imm_state = LS_I;
            if (line_state == LS_M) begin
                op        = OP_WR;
                needs_dir = 1'b1;
            end else if (line_state == LS_S) begin
                op        = OP_INV;
                needs_dir = 1'b1;
            end
        end else if (is_st) begin
            if (line_state == LS_I) begin
                op        = OP_RWITM;
                needs_dir = 1'b1;
            end else if (line_state == LS_S) begin
                op        = OP_UPD;
                needs_dir = 1'b1;
            end
        end else if (line_state == LS_I) begin
            op        = OP_RD;
            needs_dir = 1'b1;
        end
    end

endmodule

// File: rtl/cache_dir_agent.sv
// Cache-side MSI directory agent: issues miss/upgrade/evict requests, collects replies and
// services INV / forwarded-RD snoops. Define DIR_TIMEOUT_EN for the reply-timeout reissue.
module cache_dir_agent
    import coh_pkg::*;
#(
    parameter int unsigned MY_ID       = 1,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_st,
    input  logic              req_evict,
    input  logic [1:0]        req_line_state,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_data,

    cache_dir_agent_if.master dir,

    output logic              resp_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [LINE_W-1:0] resp_data,
    output logic [1:0]        resp_new_state,

    output logic              snp_valid,
    output logic              snp_inv,
    output logic [ADDR_W-1:0] snp_addr,
    input  logic              snp_ack,
    input  logic              snp_dirty,
    input  logic [LINE_W-1:0] snp_data,

    output logic              err_timeout
);

    localparam logic [SRC_W-1:0] MY_SRC = SRC_W'(MY_ID);

    if (MY_ID == 0 || MY_ID > 2 || TIMEOUT_CYC == 0) begin : g_cfg_err
        $error("cache_dir_agent: MY_ID must be 1 or 2 and TIMEOUT_CYC nonzero");
    end

    agent_state_e      state_q, state_d;
    agent_state_e      ret_q, ret_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic [1:0]        new_state_q, new_state_d;
    logic [ADDR_W-1:0] snp_addr_q, snp_addr_d;
    logic              snp_inv_q, snp_inv_d;
    logic [LINE_W-1:0] wb_data_q, wb_data_d;

`ifdef DIR_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    op_e        map_op;
    logic       map_needs_dir;
    logic [1:0] map_imm_state;

    cache_dir_req_map u_req_map (
        .is_st      (req_is_st),
        .evict      (req_evict),
        .line_state (req_line_state),
        .op         (map_op),
        .needs_dir  (map_needs_dir),
        .imm_state  (map_imm_state)
    );

    op_e  msg_op;
    logic msg_for_me;
    logic msg_is_snoop;
    logic msg_is_reply;

    always_comb begin
        msg_op       = op_e'(dir.dir_msg_op);
        msg_for_me   = dir.dir_msg_valid && (dir.dir_msg_dest == MY_SRC);
        msg_is_snoop = msg_for_me && (msg_op == OP_INV || msg_op == OP_RD);
        msg_is_reply = msg_for_me && (msg_op == OP_REPLY) && (dir.dir_msg_addr == addr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            op_q        <= OP_NOOP;
            addr_q      <= '0;
            data_q      <= '0;
            new_state_q <= LS_I;
            snp_addr_q  <= '0;
            snp_inv_q   <= 1'b0;
            wb_data_q   <= '0;
`ifdef DIR_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            new_state_q <= new_state_d;
            snp_addr_q  <= snp_addr_d;
            snp_inv_q   <= snp_inv_d;
            wb_data_q   <= wb_data_d;
`ifdef DIR_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        new_state_d = new_state_q;
        snp_addr_d  = snp_addr_q;
        snp_inv_d   = snp_inv_q;
        wb_data_d   = wb_data_q;
`ifdef DIR_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Any pending directory message blocks new requests, even one that is dropped.
                if (dir.dir_msg_valid) begin
                    if (msg_is_snoop) begin
                        snp_addr_d = dir.dir_msg_addr;
                        snp_inv_d  = (msg_op == OP_INV);
                        ret_d      = ST_IDLE;
                        state_d    = ST_SNP_LOOK;
                    end
                end else if (req_valid) begin
                    op_d        = map_op;
                    addr_d      = req_addr;
                    data_d      = req_data;
                    new_state_d = map_imm_state;
                    state_d     = map_needs_dir ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (dir.dir_req_ready) begin
                    if (op_q == OP_WR || op_q == OP_INV) begin
                        new_state_d = LS_I;
                        state_d     = ST_DONE;
                    end else begin
                        state_d     = ST_WAIT_RPY;
`ifdef DIR_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_WAIT_RPY: begin
                if (msg_is_snoop) begin
                    snp_addr_d = dir.dir_msg_addr;
                    snp_inv_d  = (msg_op == OP_INV);
                    ret_d      = ST_WAIT_RPY;
                    state_d    = ST_SNP_LOOK;
                end else if (msg_is_reply) begin
                    data_d      = dir.dir_msg_data;
                    new_state_d = fill_state(op_q);
                    state_d     = ST_DONE;
                end else begin
`ifdef DIR_TIMEOUT_EN
                    if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
`endif
                end
            end
            ST_SNP_LOOK: begin
                if (snp_ack) begin
                    if (snp_dirty) begin
                        wb_data_d = snp_data;
                        state_d   = ST_SNP_WB;
                    end else begin
                        state_d   = ret_q;
                    end
                end
            end
            ST_SNP_WB: begin
                if (dir.dir_req_ready) begin
                    state_d = ret_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready         = (state_q == ST_IDLE) && !dir.dir_msg_valid;
        dir.dir_msg_ready = (state_q == ST_IDLE) || (state_q == ST_WAIT_RPY);

        dir.dir_req_valid = (state_q == ST_SEND) || (state_q == ST_SNP_WB);
        dir.dir_req_src   = MY_SRC;
        dir.dir_req_op    = op_q;
        dir.dir_req_addr  = addr_q;
        dir.dir_req_data  = data_q;
        if (state_q == ST_SNP_WB) begin
            dir.dir_req_op   = OP_WR;
            dir.dir_req_addr = snp_addr_q;
            dir.dir_req_data = wb_data_q;
        end

        resp_valid     = (state_q == ST_DONE);
        resp_addr      = addr_q;
        resp_data      = data_q;
        resp_new_state = new_state_q;

        snp_valid = (state_q == ST_SNP_LOOK);
        snp_inv   = snp_inv_q;
        snp_addr  = snp_addr_q;

`ifdef DIR_TIMEOUT_EN
        err_timeout = err_q;
`else
        err_timeout = 1'b0;
`endif
    end

endmodule

// File: doc/cache_dir_agent.md
Name: cache_dir_agent

Overview:
- Cache-side coherence agent: the requester/responder end of the two-cache MSI directory protocol.
- Converts cache misses, upgrades and evictions into directory requests, then collects the REPLY and reports it back to the cache.
- Services directory-originated INV and forwarded-RD snoops aimed at this cache, writing back dirty data when required.
- One instance per L1 cache, placed between the cache controller and the directory.

Parameters:
- MY_ID, 1, source/dest ID of this cache (1 or 2; 0 reserved).
- ADDR_W, 32, line address width.
- LINE_W, 128, cache line data width.
- TIMEOUT_CYC, 255, reply timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache request valid.
- req_ready  out  1  agent can accept a request.
- req_is_st  in  1  request is a store.
- req_evict  in  1  request is an eviction.
- req_line_state  in  2  current local state (I=0, S=1, M=2).
- req_addr  in  ADDR_W  line address.
- req_data  in  LINE_W  dirty data for an M eviction.
- dir_req_valid  out  1  request to directory valid.
- dir_req_ready  in  1  directory accepts the request.
- dir_req_op  out  3  protocol opcode.
- dir_req_src  out  2  always MY_ID.
- dir_req_addr  out  ADDR_W  request address.
- dir_req_data  out  LINE_W  write-back data.
- dir_msg_valid  in  1  directory message valid.
- dir_msg_ready  out  1  agent accepts the message.
- dir_msg_op  in  3  message opcode.
- dir_msg_dest  in  2  target cache ID.
- dir_msg_addr  in  ADDR_W  message address.
- dir_msg_data  in  LINE_W  message data.
- resp_valid  out  1  one-cycle completion pulse to the cache.
- resp_addr  out  ADDR_W  completed line address.
- resp_data  out  LINE_W  fill data.
- resp_new_state  out  2  new local line state.
- snp_valid  out  1  snoop to cache valid.
- snp_inv  out  1  1 = invalidate, 0 = downgrade to S.
- snp_addr  out  ADDR_W  snoop address.
- snp_ack  in  1  cache finished the snoop lookup.
- snp_dirty  in  1  line was M.
- snp_data  in  LINE_W  dirty data returned by the cache.
- err_timeout  out  1  sticky reply-timeout flag.

Behaviour:
- Opcodes: NOOP=0, REPLY=2, RD=3, WR=4, INV=5, UPD=6, RWITM=7.
- Request opcode mapping:
  - evict with state M -> WR, carrying req_data.
  - evict with state S -> INV.
  - evict with state I -> no directory traffic; resp_new_state=I one cycle later.
  - load -> RD.
  - store with state I -> RWITM.
  - store with state S -> UPD.
  - store with state M, or load with state != I -> immediate resp, state unchanged.
- States: IDLE, SEND, WAIT_RPY, SNP_LOOK, SNP_WB, DONE.
- IDLE:
  - A pending dir_msg has priority over req_valid.
  - req_ready=1 only in IDLE with no dir_msg_valid.
  - On req handshake: latch op/addr/data, go to SEND.
- SEND:
  - Hold dir_req_* stable until dir_req_ready.
  - WR/INV are posted -> DONE with new state I.
  - RD/RWITM/UPD -> WAIT_RPY.
- WAIT_RPY:
  - REPLY with dest==MY_ID and addr==latched addr -> capture data, go to DONE.
  - New state: RD -> S; RWITM/UPD -> M.
- DONE: resp_valid pulses for exactly 1 cycle, then IDLE. Total latency = cycles in SEND + reply wait + 1.
- Snoops, accepted in IDLE or WAIT_RPY:
  - INV or RD with dest==MY_ID -> SNP_LOOK.
  - Latch the return state (IDLE or WAIT_RPY).
  - snp_inv = (op==INV).
- SNP_LOOK: snp_valid held until snp_ack. If snp_dirty -> SNP_WB, else back to the latched return state.
- SNP_WB: WR with snp_data, src=MY_ID; after dir_req_ready -> return state.
- Message acceptance:
  - Messages with dest != MY_ID, and NOOP, are accepted and dropped: dir_msg_ready=1 in IDLE/WAIT_RPY, 0 elsewhere.
  - A REPLY with a mismatched addr is dropped.
- Snoop vs pending request: a snoop to the same address as the pending request while in WAIT_RPY is serviced first; the later REPLY still completes normally.
- Reset (async, active-low):
  - state=IDLE; all valid outputs 0.
  - err_timeout=0; addr/data registers 0.
  - A transaction in flight is abandoned.

Optional Feature:
- DIR_TIMEOUT_EN defined: an 8+ bit counter runs in WAIT_RPY, cleared on entry.
  - At TIMEOUT_CYC: set err_timeout (sticky until reset) and return to SEND to reissue the same request.
  - The counter pauses during snoop servicing.
- DIR_TIMEOUT_EN undefined: no counter; err_timeout tied 0; wait is unbounded.

Decomposition:
- Shared package/header coh_pkg:
  - Opcode constants (NOOP, REPLY, RD, WR, INV, UPD, RWITM).
  - Line-state constants (I, S, M).
  - Source-ID width.
  - Agent state encoding.
- One sub-module, cache_dir_req_map: combinational mapping of (is_st, evict, line_state) -> (opcode, needs_dir, immediate_state).

Test Plan:
- Load miss, state I, addr 0x40: RD is issued with src=MY_ID. Directory replies REPLY, data 0xA5..A5, 3 cycles later -> resp_valid 1 cycle, resp_new_state=S, data matches.
- Store, state S, addr 0x80 -> UPD issued; REPLY -> resp_new_state=M. Store with state M -> resp next cycle, no dir_req_valid.
- Evict M, addr 0xC0, data 0x1234 -> WR issued with that data, no wait; resp_new_state=I.
- In WAIT_RPY for RD 0x40, INV to dest=MY_ID at 0x100 with snp_dirty=1:
  - snp_inv=1.
  - WR(0x100) issued.
  - Return to WAIT_RPY.
  - Later REPLY completes 0x40 with state S.
- Messages with dest=other ID, and a REPLY with the wrong addr, are accepted and dropped; state unchanged. Assert rst=0 mid-SEND -> all valids 0 immediately, state IDLE.
- With DIR_TIMEOUT_EN and TIMEOUT_CYC=8, no REPLY arrives -> err_timeout=1 at cycle 8 and RD is reissued; the subsequent REPLY completes normally.
